// File: rtl/mem_arb_pkg.sv
// ============================================================================
// mem_arb_pkg: shared types and defaults for the memory port arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } owner_t;

    localparam int STARVE_LIMIT_DEF = 4;

endpackage

`default_nettype wire

// File: rtl/mem_arb_age_counter.sv
// ============================================================================
// mem_arb_age_counter: saturating counter with clear priority and saturation flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_arb_age_counter #(
    parameter int AGE_W = 3,
    parameter int LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam logic [AGE_W-1:0] LIMIT_V = AGE_W'(LIMIT);

    logic [AGE_W-1:0] count_q;
    logic [AGE_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != LIMIT_V)) begin
            count_d = count_q + AGE_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign sat_o = (count_q == LIMIT_V);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter: shares one memory between fetch (I) and load/store (D), D>I with aging.
// Optional MEM_ARB_RANGE_CHK_EN adds alignment/range checking with an Err output. Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_BYTES    = 1024,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int AGE_W        = 3
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              I_Req,
    input  logic [ADDR_W-1:0] I_Addr,
    output logic              I_Done,
    output logic [DATA_W-1:0] I_Rdata,
    input  logic              D_Req,
    input  logic              D_We,
    input  logic [ADDR_W-1:0] D_Addr,
    input  logic [DATA_W-1:0] D_Wdata,
    output logic              D_Done,
    output logic [DATA_W-1:0] D_Rdata,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] Addr,
    output logic [DATA_W-1:0] Wd,
    input  logic [DATA_W-1:0] Rd,
`ifdef MEM_ARB_RANGE_CHK_EN
    output logic              Err,
`endif
    output logic              Busy
);

    if (((2 ** AGE_W) <= STARVE_LIMIT) || (MEM_BYTES < 4)) begin : g_param_check
        $error("mem_port_arbiter: AGE_W cannot hold STARVE_LIMIT or MEM_BYTES too small");
    end

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_done_q, i_done_d;
    logic              d_done_q, d_done_d;

    logic              w_grant_i;
    logic [ADDR_W-1:0] w_win_addr;
    logic              w_age_inc;
    logic              w_age_clr;
    logic              w_age_sat;

    assign w_grant_i  = I_Req && (!D_Req || w_age_sat);
    assign w_win_addr = w_grant_i ? I_Addr : D_Addr;

`ifdef MEM_ARB_RANGE_CHK_EN
    logic              err_q, err_d;
    logic [ADDR_W:0]   w_last_byte;
    logic              w_range_bad;

    // One extra bit so addresses near the top of the space cannot wrap past the limit.
    assign w_last_byte = {1'b0, w_win_addr} + (ADDR_W+1)'(3);
    assign w_range_bad = (w_win_addr[1:0] != 2'b00) ||
                         (w_last_byte >= (ADDR_W+1)'(MEM_BYTES));
`endif

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_done_d  = 1'b0;
        d_done_d  = 1'b0;
        w_age_inc = 1'b0;
        w_age_clr = 1'b0;
`ifdef MEM_ARB_RANGE_CHK_EN
        err_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                w_age_clr = !I_Req || w_grant_i;
                w_age_inc = I_Req && D_Req && !w_grant_i;
                if (I_Req || D_Req) begin
                    owner_d = w_grant_i ? OWN_I : OWN_D;
                    addr_d  = w_win_addr;
                    we_d    = w_grant_i ? 1'b0 : D_We;
                    wdata_d = w_grant_i ? wdata_q : D_Wdata;
                    state_d = ACCESS;
`ifdef MEM_ARB_RANGE_CHK_EN
                    if (w_range_bad) begin
                        state_d  = DONE;
                        err_d    = 1'b1;
                        i_done_d = w_grant_i;
                        d_done_d = !w_grant_i;
                        if (w_grant_i) begin
                            i_rdata_d = '0;
                        end else if (!D_We) begin
                            d_rdata_d = '0;
                        end
                    end
`endif
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    if (owner_q == OWN_I) begin
                        i_rdata_d = Rd;
                    end else begin
                        d_rdata_d = Rd;
                    end
                end
                i_done_d = (owner_q == OWN_I);
                d_done_d = (owner_q == OWN_D);
                state_d  = DONE;
            end
            DONE: begin
                owner_d = NONE;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= IDLE;
            owner_q   <= NONE;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
        end
    end

`ifdef MEM_ARB_RANGE_CHK_EN
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign Err = err_q;
`endif

    mem_arb_age_counter #(
        .AGE_W (AGE_W),
        .LIMIT (STARVE_LIMIT)
    ) u_age (
        .clk_i  (Clk),
        .rst_ni (Rst_n),
        .inc_i  (w_age_inc),
        .clr_i  (w_age_clr),
        .sat_o  (w_age_sat)
    );

    // Enables decode straight from state so an async reset drops them immediately.
    assign MemRead  = (state_q == ACCESS) && !we_q;
    assign MemWrite = (state_q == ACCESS) && we_q;
    assign Addr     = addr_q;
    assign Wd       = wdata_q;
    assign I_Done   = i_done_q;
    assign D_Done   = d_done_q;
    assign I_Rdata  = i_rdata_q;
    assign D_Rdata  = d_rdata_q;
    assign Busy     = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              Clk = 1'b0;
    logic              Rst_n = 1'b0;
    logic              I_Req = 1'b0;
    logic [ADDR_W-1:0] I_Addr = '0;
    logic              I_Done;
    logic [DATA_W-1:0] I_Rdata;
    logic              D_Req = 1'b0;
    logic              D_We = 1'b0;
    logic [ADDR_W-1:0] D_Addr = '0;
    logic [DATA_W-1:0] D_Wdata = '0;
    logic              D_Done;
    logic [DATA_W-1:0] D_Rdata;
    logic              MemRead;
    logic              MemWrite;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] Wd;
    logic [DATA_W-1:0] Rd;
    logic              Busy;
`ifdef MEM_ARB_RANGE_CHK_EN
    logic              Err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [0:1023];
    logic [9:0] rd_a;

    always #5 Clk = ~Clk;

    mem_port_arbiter dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .I_Req    (I_Req),
        .I_Addr   (I_Addr),
        .I_Done   (I_Done),
        .I_Rdata  (I_Rdata),
        .D_Req    (D_Req),
        .D_We     (D_We),
        .D_Addr   (D_Addr),
        .D_Wdata  (D_Wdata),
        .D_Done   (D_Done),
        .D_Rdata  (D_Rdata),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .Addr     (Addr),
        .Wd       (Wd),
        .Rd       (Rd),
`ifdef MEM_ARB_RANGE_CHK_EN
        .Err      (Err),
`endif
        .Busy     (Busy)
    );

    // Byte memory: combinational little-endian read, posedge write.
    assign rd_a = Addr[9:0];
    assign Rd = {mem[rd_a + 10'd3], mem[rd_a + 10'd2], mem[rd_a + 10'd1], mem[rd_a]};

    always @(posedge Clk) begin
        if (MemWrite) begin
            mem[rd_a]         <= Wd[7:0];
            mem[rd_a + 10'd1] <= Wd[15:8];
            mem[rd_a + 10'd2] <= Wd[23:16];
            mem[rd_a + 10'd3] <= Wd[31:24];
        end
    end

    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (MemRead !== 1'b0)  begin n_fail++; $display("FAIL rst_memread: got %b want 0", MemRead); end
        n_checks++; if (MemWrite !== 1'b0) begin n_fail++; $display("FAIL rst_memwrite: got %b want 0", MemWrite); end
        n_checks++; if (Addr !== 32'h0)    begin n_fail++; $display("FAIL rst_addr: got %h want 0", Addr); end
        n_checks++; if (Wd !== 32'h0)      begin n_fail++; $display("FAIL rst_wd: got %h want 0", Wd); end
        n_checks++; if (I_Done !== 1'b0 || D_Done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b%b want 00", I_Done, D_Done); end
        n_checks++; if (I_Rdata !== 32'h0 || D_Rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h %h want 0 0", I_Rdata, D_Rdata); end
        n_checks++; if (Busy !== 1'b0)     begin n_fail++; $display("FAIL rst_busy: got %b want 0", Busy); end
        @(negedge Clk);
        Rst_n = 1'b1;
        step();
    endtask

    task automatic test_fetch();
        I_Addr = 32'h10;
        I_Req  = 1'b1;
        step();
        n_checks++; if (MemRead !== 1'b1 || MemWrite !== 1'b0) begin n_fail++; $display("FAIL fetch_enables: got rd=%b wr=%b want rd=1 wr=0", MemRead, MemWrite); end
        n_checks++; if (Addr !== 32'h10) begin n_fail++; $display("FAIL fetch_addr: got %h want 00000010", Addr); end
        n_checks++; if (Busy !== 1'b1)   begin n_fail++; $display("FAIL fetch_busy: got %b want 1", Busy); end
        step();
        I_Req = 1'b0;
        n_checks++; if (I_Done !== 1'b1 || D_Done !== 1'b0) begin n_fail++; $display("FAIL fetch_done: got i=%b d=%b want i=1 d=0", I_Done, D_Done); end
        n_checks++; if (I_Rdata !== 32'h11223344) begin n_fail++; $display("FAIL fetch_rdata: got %h want 11223344", I_Rdata); end
        n_checks++; if (MemRead !== 1'b0) begin n_fail++; $display("FAIL fetch_done_memread: got %b want 0", MemRead); end
        step();
        n_checks++; if (I_Done !== 1'b0 || Busy !== 1'b0) begin n_fail++; $display("FAIL fetch_idle: got done=%b busy=%b want 0 0", I_Done, Busy); end
        n_checks++; if (Addr !== 32'h10) begin n_fail++; $display("FAIL fetch_addr_hold: got %h want 00000010", Addr); end
    endtask

    task automatic test_store_load();
        D_Addr  = 32'h20;
        D_We    = 1'b1;
        D_Wdata = 32'hDEADBEEF;
        D_Req   = 1'b1;
        step();
        n_checks++; if (MemWrite !== 1'b1 || MemRead !== 1'b0) begin n_fail++; $display("FAIL store_enables: got wr=%b rd=%b want wr=1 rd=0", MemWrite, MemRead); end
        n_checks++; if (Wd !== 32'hDEADBEEF || Addr !== 32'h20) begin n_fail++; $display("FAIL store_bus: got wd=%h addr=%h want deadbeef 00000020", Wd, Addr); end
        step();
        D_Req = 1'b0;
        n_checks++; if (D_Done !== 1'b1 || I_Done !== 1'b0) begin n_fail++; $display("FAIL store_done: got d=%b i=%b want d=1 i=0", D_Done, I_Done); end
        n_checks++; if (MemWrite !== 1'b0) begin n_fail++; $display("FAIL store_wr_drop: got %b want 0", MemWrite); end
        n_checks++; if ({mem[35], mem[34], mem[33], mem[32]} !== 32'hDEADBEEF) begin n_fail++; $display("FAIL store_mem: got %h want deadbeef", {mem[35], mem[34], mem[33], mem[32]}); end
        n_checks++; if (D_Rdata !== 32'h0) begin n_fail++; $display("FAIL store_rdata_hold: got %h want 0", D_Rdata); end
        step();
        D_We    = 1'b0;
        D_Wdata = '0;
        D_Req   = 1'b1;
        step();
        n_checks++; if (MemRead !== 1'b1 || MemWrite !== 1'b0) begin n_fail++; $display("FAIL load_enables: got rd=%b wr=%b want rd=1 wr=0", MemRead, MemWrite); end
        step();
        D_Req = 1'b0;
        n_checks++; if (D_Done !== 1'b1) begin n_fail++; $display("FAIL load_done: got %b want 1", D_Done); end
        n_checks++; if (D_Rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_rdata: got %h want deadbeef", D_Rdata); end
        step();
        n_checks++; if (D_Done !== 1'b0) begin n_fail++; $display("FAIL load_done_pulse: got %b want 0", D_Done); end
    endtask

    task automatic test_starvation();
        logic exp_i [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int   k = 0;
        I_Addr = 32'h10;
        D_Addr = 32'h30;
        D_We   = 1'b0;
        I_Req  = 1'b1;
        D_Req  = 1'b1;
        for (int c = 0; c < 60 && k < 10; c++) begin
            step();
            if (I_Done === 1'b1 && D_Done === 1'b1) begin
                n_checks++; n_fail++;
                $display("FAIL starve_both_done: got i=1 d=1 want at most one");
            end
            if (I_Done === 1'b1 || D_Done === 1'b1) begin
                n_checks++;
                if (I_Done !== exp_i[k]) begin
                    n_fail++;
                    $display("FAIL starve_order grant %0d: got %s want %s", k, I_Done ? "I" : "D", exp_i[k] ? "I" : "D");
                end
                if (I_Done === 1'b1) begin
                    n_checks++;
                    if (I_Rdata !== 32'h11223344) begin n_fail++; $display("FAIL starve_i_rdata: got %h want 11223344", I_Rdata); end
                end
                k++;
            end
        end
        I_Req = 1'b0;
        D_Req = 1'b0;
        if (k < 10) begin
            n_checks++; n_fail++;
            $display("FAIL starve_timeout: got %0d grants want 10", k);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int gap = 0;
        I_Addr = 32'h20;
        D_Addr = 32'h10;
        D_We   = 1'b0;
        I_Req  = 1'b1;
        D_Req  = 1'b1;
        step();
        n_checks++; if (MemRead !== 1'b1 || Addr !== 32'h10) begin n_fail++; $display("FAIL b2b_d_wins: got rd=%b addr=%h want rd=1 addr=00000010", MemRead, Addr); end
        step();
        D_Req = 1'b0;
        n_checks++; if (D_Done !== 1'b1 || I_Done !== 1'b0) begin n_fail++; $display("FAIL b2b_d_done: got d=%b i=%b want d=1 i=0", D_Done, I_Done); end
        n_checks++; if (D_Rdata !== 32'h11223344) begin n_fail++; $display("FAIL b2b_d_rdata: got %h want 11223344", D_Rdata); end
        for (int c = 1; c <= 8 && gap == 0; c++) begin
            step();
            if (I_Done === 1'b1) gap = c;
        end
        I_Req = 1'b0;
        n_checks++; if (gap != 3) begin n_fail++; $display("FAIL b2b_gap: got %0d cycles want 3", gap); end
        n_checks++; if (I_Rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b2b_i_rdata: got %h want deadbeef", I_Rdata); end
        step();
    endtask

    task automatic test_reset_abort();
        int done_seen = 0;
        D_Addr  = 32'h40;
        D_We    = 1'b1;
        D_Wdata = 32'h55;
        D_Req   = 1'b1;
        step();
        n_checks++; if (MemWrite !== 1'b1) begin n_fail++; $display("FAIL abort_wr_before: got %b want 1", MemWrite); end
        #2;
        Rst_n = 1'b0;
        D_Req = 1'b0;
        #1;
        n_checks++; if (MemWrite !== 1'b0 || Busy !== 1'b0) begin n_fail++; $display("FAIL abort_async: got wr=%b busy=%b want 0 0", MemWrite, Busy); end
        n_checks++; if (D_Rdata !== 32'h0 || Addr !== 32'h0) begin n_fail++; $display("FAIL abort_regs: got rdata=%h addr=%h want 0 0", D_Rdata, Addr); end
        step();
        n_checks++; if (mem[10'h40] !== 8'hA5) begin n_fail++; $display("FAIL abort_mem: got %h want a5", mem[10'h40]); end
        Rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (D_Done === 1'b1) done_seen++;
            step();
        end
        n_checks++; if (done_seen != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d done pulses want 0", done_seen); end
    endtask

`ifdef MEM_ARB_RANGE_CHK_EN
    task automatic test_range_check();
        D_Addr = 32'h3FE;
        D_We   = 1'b0;
        D_Req  = 1'b1;
        step();
        D_Req = 1'b0;
        n_checks++; if (D_Done !== 1'b1 || Err !== 1'b1) begin n_fail++; $display("FAIL range_done_err: got d=%b err=%b want 1 1", D_Done, Err); end
        n_checks++; if (MemRead !== 1'b0 || D_Rdata !== 32'h0) begin n_fail++; $display("FAIL range_no_access: got rd=%b rdata=%h want 0 0", MemRead, D_Rdata); end
        step();
        n_checks++; if (Err !== 1'b0) begin n_fail++; $display("FAIL range_err_pulse: got %b want 0", Err); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[16] = 8'h44; mem[17] = 8'h33; mem[18] = 8'h22; mem[19] = 8'h11;
        mem[48] = 8'h78; mem[49] = 8'h56; mem[50] = 8'h34; mem[51] = 8'h12;
        mem[64] = 8'hA5;

        test_reset();
        test_fetch();
        test_store_load();
        test_starvation();
        test_back_to_back();
        test_reset_abort();
`ifdef MEM_ARB_RANGE_CHK_EN
        test_range_check();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
